// File: rtl/mul_pkg.sv
// Shared types for the dot-product sequencer.
// Holds the FSM state encoding and the latency token layout.
package mul_pkg;

  localparam int SIZE_DEF = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    OUT
  } state_t;

  typedef struct packed {
    logic vld;
    logic last;
  } tok_t;

endpackage

// File: rtl/mul_tok_pipe.sv
// Token shift line that shadows the external multiplier.
// Each stage carries {vld,last}; clr empties the whole line.
module mul_tok_pipe
  import mul_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  tok_t din,
  output tok_t dout
);

  tok_t line [DEPTH];

  // shift one stage per clock, synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++)
        line[i] <= '0;
    end else begin
      line[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        line[i] <= line[i-1];
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/mul_dot_acc.sv
// Dot-product sequencer around an external pipelined multiplier.
// Launches pairs, accumulates returned products, emits one sum per frame.
module mul_dot_acc
  import mul_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int MUL_LAT = 1,
  parameter int ACC_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  input  logic              in_last,
  output logic [SIZE-1:0]   mul_a,
  output logic [SIZE-1:0]   mul_b,
  input  logic [2*SIZE-1:0] mul_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             acpt;
  tok_t             tok_in;
  tok_t             tok_out;
  logic [ACC_W:0]   sum;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_nx;
  logic             ovf_nx;

  assign acpt = in_valid & in_ready;

  // Stage 0 sits beside mul_a/mul_b, so the last stage lines up with mul_out.
  assign tok_in.vld  = acpt;
  assign tok_in.last = acpt & in_last;

  mul_tok_pipe #(
    .DEPTH (MUL_LAT + 1)
  ) u_tok (
    .clk  (clk),
    .clr  (rst),
    .din  (tok_in),
    .dout (tok_out)
  );

  // next accumulator, count and sticky overflow for an exiting product
  always_comb begin
    sum     = {1'b0, acc} + (ACC_W+1)'(mul_out);
    cnt_sat = &cnt;
    cnt_nx  = cnt_sat ? cnt : cnt + CNT_W'(1);
    ovf_nx  = ovf | sum[ACC_W] | cnt_sat;
  end

  // operand launch registers, zeroed on idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (acpt) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end else begin
      mul_a <= '0;
      mul_b <= '0;
    end
  end

  // running frame sum; the last product restarts it from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (tok_out.vld) begin
      if (tok_out.last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt_nx;
        ovf <= ovf_nx;
      end
    end
  end

  // frame FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (acpt && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (tok_out.vld && tok_out.last) begin
            state     <= OUT;
            out_acc   <= sum[ACC_W-1:0];
            out_cnt   <= cnt_nx;
            out_ovf   <= ovf_nx;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= RUN;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_dot_acc.sv
// Bench for mul_dot_acc with a registered multiplier model.
// Expected frame results are queued; a monitor pops on each handshake.
module tb_mul_dot_acc;

  localparam int SIZE    = 4;
  localparam int MUL_LAT = 1;
  localparam int ACC_W   = 8;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   in_a;
  logic [SIZE-1:0]   in_b;
  logic              in_last;
  logic [SIZE-1:0]   mul_a;
  logic [SIZE-1:0]   mul_b;
  logic [2*SIZE-1:0] mul_out;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  logic [2*SIZE-1:0] mpipe [MUL_LAT];

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mul_dot_acc #(
    .SIZE    (SIZE),
    .MUL_LAT (MUL_LAT),
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mpipe[0] <= (2*SIZE)'(mul_a) * (2*SIZE)'(mul_b);
    for (int i = 1; i < MUL_LAT; i++)
      mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[MUL_LAT-1];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got acc %0d want none",
                 out_acc);
      end else begin
        e = exp_q.pop_front();
        chk("res_acc", int'(out_acc), int'(e.acc));
        chk("res_cnt", int'(out_cnt), int'(e.cnt));
        chk("res_ovf", int'(out_ovf), int'(e.ovf));
      end
    end
  end

  task automatic expect_res(input int a, input int c, input int o);
    res_t e;
    e.acc = ACC_W'(a);
    e.cnt = CNT_W'(c);
    e.ovf = o[0];
    exp_q.push_back(e);
  endtask

  task automatic send(input int a, input int b, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_a     = SIZE'(a);
    in_b     = SIZE'(b);
    in_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_timeout got out_valid 0 want 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0",
               exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_acc",   int'(out_acc),   0);
    chk("rst_out_cnt",   int'(out_cnt),   0);
    chk("rst_out_ovf",   int'(out_ovf),   0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_mul_a",     int'(mul_a),     0);
    chk("rst_mul_b",     int'(mul_b),     0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // frame of three, back-to-back: 15+225+0
    expect_res(240, 3, 0);
    send(3, 5, 1'b0);
    send(15, 15, 1'b0);
    send(0, 9, 1'b1);
    wait_out(n);
    chk("lat_frame3", n, MUL_LAT + 2);
    @(negedge clk);
    chk("ready_after_take", int'(in_ready), 1);
    drain();

    // single-pair frame
    expect_res(14, 1, 0);
    send(7, 2, 1'b1);
    chk("ready_low_drain", int'(in_ready), 0);
    wait_out(n);
    chk("ready_low_out", int'(in_ready), 0);
    drain();

    // backpressure with a pair waiting upstream
    out_ready = 1'b0;
    expect_res(30, 1, 0);
    send(5, 6, 1'b1);
    wait_out(n);
    in_valid = 1'b1;
    in_a     = 4'd4;
    in_b     = 4'd4;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_acc",   int'(out_acc),   30);
      chk("hold_cnt",   int'(out_cnt),   1);
      chk("hold_ready", int'(in_ready),  0);
      @(negedge clk);
    end
    expect_res(16, 1, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_still_out", int'(in_ready), 0);
    @(negedge clk);
    chk("release_run", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();

    // gapped frame: bubbles must not add
    expect_res(5, 2, 0);
    send(1, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(2, 2, 1'b1);
    drain();

    // accumulator carry-out: 450 mod 256
    expect_res(194, 2, 1);
    send(15, 15, 1'b0);
    send(15, 15, 1'b1);
    drain();
    expect_res(1, 1, 0);
    send(1, 1, 1'b1);
    drain();

    // reset pulse one cycle after a mid-frame accept
    send(9, 9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_acc",   int'(out_acc),   0);
    chk("mid_rst_cnt",   int'(out_cnt),   0);
    chk("mid_rst_ready", int'(in_ready),  1);
    expect_res(6, 1, 0);
    send(2, 3, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
